// File: rtl/dct_pkg.sv
// Constants shared by the 16-point DCT datapath stages.
package dct_pkg;
  localparam int DCT_N16          = 16;
  localparam int SA16_LATENCY     = 4;
  localparam int DEFAULT_IN_WIDTH = 16;
  localparam int DEFAULT_WIDTH    = 20;
endpackage

// File: rtl/butterfly16_load_if.sv
// Sample stream in, butterfly sums/differences and row markers out.
interface butterfly16_load_if
  import dct_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
  parameter int WIDTH    = DEFAULT_WIDTH
);
  logic                       in_valid;
  logic                       in_first;
  logic signed [IN_WIDTH-1:0] in_data;
  logic                       out_valid;
  logic signed [WIDTH-1:0]    a [DCT_N16/2];
  logic signed [WIDTH-1:0]    b [DCT_N16/2];
  logic                       odd_valid;
  logic                       sync_err;

  modport master (
    output in_valid, in_first, in_data,
    input  out_valid, a, b, odd_valid, sync_err
  );

  modport slave (
    input  in_valid, in_first, in_data,
    output out_valid, a, b, odd_valid, sync_err
  );
endinterface

// File: rtl/vld_delay.sv
// Fixed-depth valid delay line used to align markers with pipelined DCT stages.
module vld_delay
  import dct_pkg::*;
#(
  parameter int DEPTH = SA16_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  output logic o_vld
);
  logic [DEPTH-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else begin
      r_shift <= (r_shift << 1) | DEPTH'(i_vld);
    end
  end

  assign o_vld = r_shift[DEPTH-1];
endmodule

// File: rtl/butterfly16_load.sv
// Collects a 16-sample row serially and registers the first-stage butterfly
// (even sums a_k, odd differences b_k) on the edge that accepts sample 15.
module butterfly16_load
  import dct_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  butterfly16_load_if.slave bus
);
  localparam int HALF = DCT_N16 / 2;
  localparam int CW   = $clog2(DCT_N16);
  localparam logic [CW-1:0] LAST_IDX = CW'(DCT_N16 - 1);

  logic [CW-1:0]              r_cnt;
  logic signed [IN_WIDTH-1:0] r_buf [DCT_N16-1];
  logic signed [WIDTH-1:0]    r_a [HALF];
  logic signed [WIDTH-1:0]    r_b [HALF];
  logic                       r_outValid;
  logic                       r_syncErr;
  logic signed [WIDTH-1:0]    w_a [HALF];
  logic signed [WIDTH-1:0]    w_b [HALF];
  logic                       w_last;
  logic                       w_oddValid;

  assign w_last = bus.in_valid && !bus.in_first && (r_cnt == LAST_IDX);

  // Sample 15 is never stored; it feeds the k=0 butterfly straight from the input.
  for (genvar gk = 0; gk < HALF; gk++) begin : g_bfly
    logic signed [WIDTH-1:0] w_lo;
    logic signed [WIDTH-1:0] w_hi;

    assign w_lo = {{(WIDTH-IN_WIDTH){r_buf[gk][IN_WIDTH-1]}}, r_buf[gk]};
    if (gk == 0) begin : g_edge
      assign w_hi = {{(WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    end else begin : g_mid
      assign w_hi = {{(WIDTH-IN_WIDTH){r_buf[DCT_N16-1-gk][IN_WIDTH-1]}},
                     r_buf[DCT_N16-1-gk]};
    end
    assign w_a[gk]   = w_lo + w_hi;
    assign w_b[gk]   = w_lo - w_hi;
    assign bus.a[gk] = r_a[gk];
    assign bus.b[gk] = r_b[gk];
  end

  // An in_first arriving mid-row restarts framing and drops the partial row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_syncErr  <= 1'b0;
      for (int i = 0; i < DCT_N16 - 1; i++) r_buf[i] <= '0;
      for (int i = 0; i < HALF; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_outValid <= w_last;
      r_syncErr  <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_first) begin
          r_buf[0]  <= bus.in_data;
          r_cnt     <= CW'(1);
          r_syncErr <= (r_cnt != '0);
        end else begin
          if (r_cnt != LAST_IDX) r_buf[r_cnt] <= bus.in_data;
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_last) begin
        for (int i = 0; i < HALF; i++) begin
          r_a[i] <= w_a[i];
          r_b[i] <= w_b[i];
        end
      end
    end
  end

  vld_delay #(.DEPTH(SA16_LATENCY)) u_oddDelay (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_outValid),
    .o_vld (w_oddValid)
  );

  assign bus.out_valid = r_outValid;
  assign bus.sync_err  = r_syncErr;
  assign bus.odd_valid = w_oddValid;
endmodule

// File: tb/tb_butterfly16_load.sv
// Directed bench: a reference row model pushes expected butterflies into a
// scoreboard that is drained whenever the design raises out_valid.
module tb_butterfly16_load;
  import dct_pkg::*;

  localparam int IW = DEFAULT_IN_WIDTH;
  localparam int W  = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  butterfly16_load_if #(.IN_WIDTH(IW), .WIDTH(W)) bus ();

  butterfly16_load #(.IN_WIDTH(IW), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int testCount = 0;
  int failCount = 0;
  int scoreQ[$];
  int mCnt = 0;
  int mBuf[16];
  int heldA[8];
  int heldB[8];
  int row[16];
  bit [SA16_LATENCY-1:0] ovHist = '0;
  int cycle = 0;
  int lastPulse = -1;
  int pulseGap = 0;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: update the reference model, clock, then check everything.
  task automatic applyStimulus(input bit v, input bit f, input int d, input bit r);
    bit expOv;
    bit expSe;
    bit expOdd;
    expOv  = 1'b0;
    expSe  = 1'b0;
    expOdd = 1'b0;
    rst          = r;
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_data  = IW'(d);
    if (r) begin
      mCnt = 0;
      foreach (mBuf[i]) mBuf[i] = 0;
      foreach (heldA[i]) begin
        heldA[i] = 0;
        heldB[i] = 0;
      end
      ovHist = '0;
      scoreQ.delete();
    end else begin
      if (v) begin
        if (f) begin
          expSe   = (mCnt != 0);
          mBuf[0] = d;
          mCnt    = 1;
        end else begin
          mBuf[mCnt] = d;
          if (mCnt == 15) begin
            expOv = 1'b1;
            for (int k = 0; k < 8; k++) scoreQ.push_back(mBuf[k] + mBuf[15-k]);
            for (int k = 0; k < 8; k++) scoreQ.push_back(mBuf[k] - mBuf[15-k]);
          end
          mCnt = (mCnt + 1) % 16;
        end
      end
      expOdd = ovHist[SA16_LATENCY-1];
      ovHist = {ovHist[SA16_LATENCY-2:0], expOv};
    end
    @(posedge clk);
    #1;
    cycle++;
    checkOutput("out_valid", bus.out_valid, expOv);
    checkOutput("sync_err", bus.sync_err, expSe);
    checkOutput("odd_valid", bus.odd_valid, expOdd);
    if (bus.out_valid === 1'b1) begin
      if (scoreQ.size() < 16) begin
        checkOutput("scoreboard_empty", scoreQ.size(), 16);
      end else begin
        for (int k = 0; k < 8; k++) heldA[k] = scoreQ.pop_front();
        for (int k = 0; k < 8; k++) heldB[k] = scoreQ.pop_front();
      end
      if (lastPulse >= 0) pulseGap = cycle - lastPulse;
      lastPulse = cycle;
    end
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("a%0d", k), bus.a[k], heldA[k]);
      checkOutput($sformatf("b%0d", k), bus.b[k], heldB[k]);
    end
  endtask

  task automatic sendRow(input bit useFirst, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps && k > 0) applyStimulus(1'b0, 1'b1, int'($urandom_range(65535)) - 32768, 1'b0);
      applyStimulus(1'b1, useFirst && (k == 0), row[k], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, int'($urandom_range(65535)) - 32768, 1'b0);
  endtask

  task automatic randomRow();
    for (int k = 0; k < 16; k++) row[k] = int'($urandom_range(65535)) - 32768;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_data  = '0;

    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1234, 1'b1);

    for (int k = 0; k < 16; k++) row[k] = k;
    sendRow(1'b1, 1'b0);
    checkOutput("ramp_a5", bus.a[5], 15);
    checkOutput("ramp_b0", bus.b[0], -15);
    checkOutput("ramp_b3", bus.b[3], -9);
    checkOutput("ramp_b7", bus.b[7], -1);
    idle(5);

    foreach (row[i]) row[i] = 0;
    row[0]  = 32767;
    row[15] = -32768;
    sendRow(1'b1, 1'b0);
    checkOutput("extreme_a0", bus.a[0], -1);
    checkOutput("extreme_b0", bus.b[0], 65535);
    idle(2);

    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, k == 0, int'($urandom_range(65535)) - 32768, 1'b0);
    randomRow();
    sendRow(1'b1, 1'b0);
    idle(6);

    randomRow();
    sendRow(1'b1, 1'b0);
    randomRow();
    sendRow(1'b0, 1'b0);
    checkOutput("row_gap", pulseGap, 16);
    randomRow();
    sendRow(1'b0, 1'b1);
    idle(6);

    // Reset with an odd_valid pulse still in flight, then reset after 10 samples.
    randomRow();
    sendRow(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 100, 1'b0);
    applyStimulus(1'b1, 1'b0, 200, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    idle(6);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, k == 0, int'($urandom_range(65535)) - 32768, 1'b0);
    applyStimulus(1'b1, 1'b0, 55, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    randomRow();
    sendRow(1'b0, 1'b0);
    idle(6);

    checkOutput("scoreboard_drained", scoreQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/butterfly16_load.md
BUTTERFLY16_LOAD -- requirements
Module: butterfly16_load

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter WIDTH, default 20: signed output width, matching the downstream 16-point odd shift-add stage; WIDTH >= IN_WIDTH+1.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  in_data carries a sample this cycle.
REQ-006 in_first  in  1  qualified by in_valid; sample is index 0 of a 16-sample row.
REQ-007 in_data  in  IN_WIDTH  signed sample x[k], k = 0..15, serial order.
REQ-008 out_valid  out  1  one-cycle pulse; a0..a7 and b0..b7 are new this cycle.
REQ-009 a0..a7  out  WIDTH each  signed even butterfly sums.
REQ-010 b0..b7  out  WIDTH each  signed odd butterfly differences; feed the odd shift-add stage directly.
REQ-011 odd_valid  out  1  out_valid delayed 4 cycles; marks the cycle the shift-add stage's y1..y15 first reflect this row.
REQ-012 sync_err  out  1  one-cycle pulse on a row misalignment.

Function
REQ-013 SHALL keep a 4-bit sample counter cnt; an accepted sample (in_valid=1) with in_first=0 is stored at buf[cnt], and cnt increments, wrapping 15->0.
REQ-014 in_valid=0 cycles SHALL hold cnt and buf unchanged; gaps of any length are legal.
REQ-015 in_valid=1 with in_first=1 SHALL store the sample at buf[0] and set cnt=1.
REQ-016 If in_first=1 is accepted while cnt != 0, sync_err SHALL pulse the next cycle and the partial row SHALL be discarded, producing no out_valid.
REQ-017 Accepting sample index 15 SHALL register outputs at that edge:
  - a_k = x[k] + x[15-k]
  - b_k = x[k] - x[15-k], k = 0..7
  - x[15] is taken from in_data directly
  - out_valid=1 for exactly the next cycle.
REQ-018 Arithmetic: operands SHALL be sign-extended to WIDTH before add/sub; the result is exact, with no saturation or truncation.
REQ-019 a/b outputs SHALL hold their last values between out_valid pulses.
REQ-020 Back-to-back rows with no idle cycles SHALL be sustained: one row per 16 accepted samples, and the next row's index 0 is accepted on the cycle after index 15.
REQ-021 odd_valid SHALL be a 4-stage shift of out_valid; pulses from consecutive rows never merge.
REQ-022 Counter state without in_first: rows are framed purely by cnt; in_first is optional after the first row.

Reset
REQ-023 While rst=1 at a clock edge:
  - cnt, buf, a0..a7, b0..b7, out_valid, odd_valid and sync_err SHALL become 0
  - the odd_valid delay line SHALL clear
  - any sample presented in that cycle SHALL be ignored.
REQ-024 Reset mid-row SHALL discard the partial row, emit no out_valid, and clear pending odd_valid pulses.
REQ-025 The first cycle after reset release SHALL accept a sample as index 0.

Structure
REQ-026 Shared package dct_pkg SHALL hold:
  - DCT_N16 = 16
  - SA16_LATENCY = 4
  - default WIDTH = 20 and IN_WIDTH = 16.
REQ-027 The odd_valid delay SHALL be one sub-module, vld_delay (parameter DEPTH = SA16_LATENCY), shared with other DCT stages.
REQ-028 The butterfly adders SHALL be in-line generate logic, not a separate module.

Verification
REQ-029 Ramp: x[k]=k, k=0..15, contiguous with in_first on k=0 -> one cycle after k=15, out_valid=1, all a_k=15, b0=-15, b3=-9, b7=-1.
REQ-030 Extremes: x[0]=32767, x[15]=-32768, others 0 -> a0=-1, b0=65535 (no wrap at WIDTH=20).
REQ-031 Misalignment: 5 samples, then in_first -> sync_err pulse next cycle, no out_valid for the partial row; the following full row produces correct output.
REQ-032 Gaps plus back-to-back:
  - rows 1 and 2 contiguous -> out_valid pulses 16 cycles apart
  - row 3 with in_valid toggling every other cycle -> correct sums and a single pulse
  - odd_valid follows each out_valid pulse by exactly 4 cycles.
REQ-033 Reset: rst asserted after 10 samples of a row -> all outputs 0, no out_valid or odd_valid; a new full row after release is correct.
